// File: rtl/bitty_fetch_unit.sv
// rtl/bitty_fetch_unit.sv - instruction fetch sequencer feeding bitty_core
// Optional halt-opcode detection is built when BITTY_FETCH_HALT_EN is defined.
module bitty_fetch_unit #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF,
   parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_instruction,
   output logic              o_run,
   input  logic              i_done,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_busy,
   output logic              o_halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_EXEC   = 3'd3,
`ifdef BITTY_FETCH_HALT_EN
      S_NEXT   = 3'd4,
      S_HALTED = 3'd5
`else
      S_NEXT   = 3'd4
`endif
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_instr;
   logic                r_done_q;
   logic                w_done_rise;
   logic                w_is_halt;
   logic                w_restart;

   // A done level carried into EXEC must fall and rise again to count.
   assign w_done_rise = i_done & ~r_done_q;

`ifdef BITTY_FETCH_HALT_EN
   assign w_is_halt = (i_mem_rdata == HALT_WORD);
   assign w_restart = i_start && (r_state == S_IDLE || r_state == S_HALTED);
`else
   assign w_is_halt = 1'b0;
   assign w_restart = i_start && (r_state == S_IDLE);
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_state_next = S_FETCH;
         S_FETCH:  w_state_next = S_WAIT;
`ifdef BITTY_FETCH_HALT_EN
         S_WAIT:   w_state_next = w_is_halt ? S_HALTED : S_EXEC;
         S_HALTED: if (i_start) w_state_next = S_FETCH;
`else
         S_WAIT:   w_state_next = S_EXEC;
`endif
         S_EXEC:   if (w_done_rise) w_state_next = S_NEXT;
         S_NEXT:   w_state_next = (r_pc == LAST_ADDR) ? S_IDLE : S_FETCH;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pc     <= '0;
         r_instr  <= '0;
         r_done_q <= 1'b0;
      end else begin
         r_done_q <= i_done;
         if (w_restart) begin
            r_pc <= '0;
         end else if (r_state == S_NEXT && r_pc != LAST_ADDR) begin
            r_pc <= r_pc + 1'b1;
         end
         if (r_state == S_WAIT && !w_is_halt) begin
            r_instr <= i_mem_rdata;
         end
      end
   end

   always_comb begin
      o_mem_rd_en = 1'b0;
      o_run       = 1'b0;
      o_busy      = 1'b1;
      o_halted    = 1'b0;
      case (r_state)
         S_IDLE:   o_busy      = 1'b0;
         S_FETCH:  o_mem_rd_en = 1'b1;
         S_EXEC:   o_run       = 1'b1;
`ifdef BITTY_FETCH_HALT_EN
         S_HALTED: begin
            o_busy   = 1'b0;
            o_halted = 1'b1;
         end
`endif
         default:  o_busy      = 1'b1;
      endcase
   end

   assign o_mem_addr    = r_pc;
   assign o_pc          = r_pc;
   assign o_instruction = r_instr;

endmodule
